dual_rename: RTL and testbench

//  Register-rename stage directly downstream of the dual-issue decode stage.

---
 rtl/rename_pkg.sv | 34 +++
 rtl/rename_free_list.sv | 58 +++++
 rtl/dual_rename.sv | 168 ++++++++++++++++
 tb/tb_dual_rename.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared types and sizing for the dual-slot rename stage and its free list.
package rename_pkg;

  localparam int unsigned NUM_AREGS = 32;
  localparam int unsigned NUM_PREGS = 64;
  localparam int unsigned FL_DEPTH  = NUM_PREGS - NUM_AREGS;
  localparam int unsigned PREG_W    = $clog2(NUM_PREGS);
  localparam int unsigned AREG_W    = $clog2(NUM_AREGS);
  localparam int unsigned FL_PTR_W  = $clog2(FL_DEPTH);
  localparam int unsigned CNT_W     = PREG_W + 1;

  typedef logic [PREG_W-1:0]   preg_t;
  typedef logic [AREG_W-1:0]   areg_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;
  typedef logic [CNT_W-1:0]    fl_cnt_t;

  typedef struct packed {
    preg_t prs1;
    preg_t prs2;
    preg_t prd;
    preg_t oldprd;
  } slot_tags_t;

  // Advance a free-list pointer by 0..2 entries, wrapping at FL_DEPTH.
  function automatic fl_ptr_t fl_ptr_add(input fl_ptr_t p, input logic [1:0] n);
    logic [FL_PTR_W:0] s;
    s = {1'b0, p} + {{(FL_PTR_W-1){1'b0}}, n};
    if (s >= (FL_PTR_W+1)'(FL_DEPTH)) begin
      s = s - (FL_PTR_W+1)'(FL_DEPTH);
    end
    return s[FL_PTR_W-1:0];
  endfunction

endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical tags: up to two pops and two pushes per cycle.
// Pops read the current head entries; pushed tags become visible only next cycle.
module rename_free_list
  import rename_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        i_pop_cnt,
  input  logic              i_push1_valid,
  input  logic [PREG_W-1:0] i_push1_tag,
  input  logic              i_push2_valid,
  input  logic [PREG_W-1:0] i_push2_tag,
  output logic [PREG_W-1:0] o_head0_c,
  output logic [PREG_W-1:0] o_head1_c,
  output logic [CNT_W-1:0]  o_count
);

  preg_t      r_mem [FL_DEPTH];
  fl_ptr_t    r_head;
  fl_ptr_t    r_tail;
  fl_cnt_t    r_count;
  fl_ptr_t    w_tail2;
  logic [1:0] w_push_cnt;
  fl_cnt_t    w_count_next;

  assign o_head0_c    = r_mem[r_head];
  assign o_head1_c    = r_mem[fl_ptr_add(r_head, 2'd1)];
  assign w_push_cnt   = 2'(i_push1_valid) + 2'(i_push2_valid);
  assign w_tail2      = fl_ptr_add(r_tail, 2'(i_push1_valid));
  assign w_count_next = r_count - fl_cnt_t'(i_pop_cnt) + fl_cnt_t'(w_push_cnt);
  assign o_count      = r_count;

  // Slot-2 push lands behind slot-1 push, or at the tail if slot 1 is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        r_mem[fl_ptr_t'(i)] <= preg_t'(NUM_AREGS + i);
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= fl_cnt_t'(FL_DEPTH);
    end else begin
      if (i_push1_valid) r_mem[r_tail]  <= i_push1_tag;
      if (i_push2_valid) r_mem[w_tail2] <= i_push2_tag;
      r_head  <= fl_ptr_add(r_head, i_pop_cnt);
      r_tail  <= fl_ptr_add(r_tail, w_push_cnt);
      r_count <= w_count_next;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    w_count_next <= fl_cnt_t'(FL_DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    fl_cnt_t'(i_pop_cnt) <= r_count);
  a_no_free_p0: assert property (@(posedge clk) disable iff (rst)
    !(i_push1_valid && (i_push1_tag == '0)) && !(i_push2_valid && (i_push2_tag == '0)));

endmodule

// File: rtl/dual_rename.sv
// Dual-slot register rename: RAT lookup with intra-bundle bypass, free-list allocation.
// Define RENAME_BUSY_TABLE_EN to add a busy-bit table and registered source-ready outputs.
module dual_rename
  import rename_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AREG_W-1:0] rs1_1,
  input  logic [AREG_W-1:0] rs2_1,
  input  logic [AREG_W-1:0] rd_1,
  input  logic [AREG_W-1:0] rs1_2,
  input  logic [AREG_W-1:0] rs2_2,
  input  logic [AREG_W-1:0] rd_2,
  input  logic              regWrite1,
  input  logic              regWrite2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PREG_W-1:0] prs1_1,
  output logic [PREG_W-1:0] prs2_1,
  output logic [PREG_W-1:0] prd_1,
  output logic [PREG_W-1:0] oldprd_1,
  output logic [PREG_W-1:0] prs1_2,
  output logic [PREG_W-1:0] prs2_2,
  output logic [PREG_W-1:0] prd_2,
  output logic [PREG_W-1:0] oldprd_2,
  input  logic              commit_valid1,
  input  logic [PREG_W-1:0] commit_preg1,
  input  logic              commit_valid2,
  input  logic [PREG_W-1:0] commit_preg2,
`ifdef RENAME_BUSY_TABLE_EN
  input  logic              wb_valid,
  input  logic [PREG_W-1:0] wb_preg,
  output logic              rdy1_1,
  output logic              rdy2_1,
  output logic              rdy1_2,
  output logic              rdy2_2,
`endif
  output logic [CNT_W-1:0]  free_count
);

  preg_t      r_rat [NUM_AREGS];
  slot_tags_t r_s1;
  slot_tags_t r_s2;
  slot_tags_t w_s1;
  slot_tags_t w_s2;
  logic       r_out_valid;
  logic       w_accept;
  logic       w_alloc1;
  logic       w_alloc2;
  logic       w_fwd1_2;
  logic       w_fwd2_2;
  logic       w_waw;
  logic [1:0] w_pop_cnt;
  preg_t      w_head0;
  preg_t      w_head1;
  fl_cnt_t    w_count;

  assign w_alloc1  = regWrite1 && (rd_1 != '0);
  assign w_alloc2  = regWrite2 && (rd_2 != '0);
  assign in_ready  = (!r_out_valid || out_ready) && (w_count >= fl_cnt_t'(2));
  assign w_accept  = in_valid && in_ready;
  assign w_pop_cnt = w_accept ? (2'(w_alloc1) + 2'(w_alloc2)) : 2'd0;
  assign w_fwd1_2  = w_alloc1 && (rs1_2 == rd_1);
  assign w_fwd2_2  = w_alloc1 && (rs2_2 == rd_1);
  assign w_waw     = w_alloc1 && (rd_2 == rd_1);

  rename_free_list u_free_list (
    .clk           (clk),
    .rst           (rst),
    .i_pop_cnt     (w_pop_cnt),
    .i_push1_valid (commit_valid1),
    .i_push1_tag   (commit_preg1),
    .i_push2_valid (commit_valid2),
    .i_push2_tag   (commit_preg2),
    .o_head0_c     (w_head0),
    .o_head1_c     (w_head1),
    .o_count       (w_count)
  );

  // Slot 2 sees slot 1's destination as if the two were renamed in program order.
  always_comb begin
    w_s1 = '0;
    w_s2 = '0;
    w_s1.prs1 = (rs1_1 == '0) ? '0 : r_rat[rs1_1];
    w_s1.prs2 = (rs2_1 == '0) ? '0 : r_rat[rs2_1];
    if (w_alloc1) begin
      w_s1.prd    = w_head0;
      w_s1.oldprd = r_rat[rd_1];
    end
    w_s2.prs1 = w_fwd1_2 ? w_s1.prd : ((rs1_2 == '0) ? '0 : r_rat[rs1_2]);
    w_s2.prs2 = w_fwd2_2 ? w_s1.prd : ((rs2_2 == '0) ? '0 : r_rat[rs2_2]);
    if (w_alloc2) begin
      w_s2.prd    = w_alloc1 ? w_head1 : w_head0;
      w_s2.oldprd = w_waw ? w_s1.prd : r_rat[rd_2];
    end
  end

  // Output register and RAT update; slot-2 write wins when both target one rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_s1        <= '0;
      r_s2        <= '0;
      for (int unsigned i = 0; i < NUM_AREGS; i++) begin
        r_rat[areg_t'(i)] <= preg_t'(i);
      end
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_s1        <= w_s1;
      r_s2        <= w_s2;
      if (w_alloc1) r_rat[rd_1] <= w_s1.prd;
      if (w_alloc2) r_rat[rd_2] <= w_s2.prd;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign prs1_1     = r_s1.prs1;
  assign prs2_1     = r_s1.prs2;
  assign prd_1      = r_s1.prd;
  assign oldprd_1   = r_s1.oldprd;
  assign prs1_2     = r_s2.prs1;
  assign prs2_2     = r_s2.prs2;
  assign prd_2      = r_s2.prd;
  assign oldprd_2   = r_s2.oldprd;
  assign free_count = w_count;

`ifdef RENAME_BUSY_TABLE_EN
  logic [NUM_PREGS-1:0] r_busy;
  logic r_rdy1_1, r_rdy2_1, r_rdy1_2, r_rdy2_2;
  logic w_rdy1_1, w_rdy2_1, w_rdy1_2, w_rdy2_2;

  // A same-cycle writeback of the looked-up tag counts as ready.
  assign w_rdy1_1 = !r_busy[w_s1.prs1] || (wb_valid && (wb_preg == w_s1.prs1));
  assign w_rdy2_1 = !r_busy[w_s1.prs2] || (wb_valid && (wb_preg == w_s1.prs2));
  assign w_rdy1_2 = !w_fwd1_2 && (!r_busy[w_s2.prs1] || (wb_valid && (wb_preg == w_s2.prs1)));
  assign w_rdy2_2 = !w_fwd2_2 && (!r_busy[w_s2.prs2] || (wb_valid && (wb_preg == w_s2.prs2)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= '0;
      r_rdy1_1 <= 1'b0;
      r_rdy2_1 <= 1'b0;
      r_rdy1_2 <= 1'b0;
      r_rdy2_2 <= 1'b0;
    end else begin
      if (wb_valid) r_busy[wb_preg] <= 1'b0;
      if (w_accept && w_alloc1) r_busy[w_s1.prd] <= 1'b1;
      if (w_accept && w_alloc2) r_busy[w_s2.prd] <= 1'b1;
      if (w_accept) begin
        r_rdy1_1 <= w_rdy1_1;
        r_rdy2_1 <= w_rdy2_1;
        r_rdy1_2 <= w_rdy1_2;
        r_rdy2_2 <= w_rdy2_2;
      end
    end
  end

  assign rdy1_1 = r_rdy1_1;
  assign rdy2_1 = r_rdy2_1;
  assign rdy1_2 = r_rdy1_2;
  assign rdy2_2 = r_rdy2_2;
`endif

endmodule

// File: tb/tb_dual_rename.sv
// Scoreboard bench for dual_rename: program-order rename model, directed cases plus random traffic.
module tb_dual_rename;

  logic       clk, rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [4:0] rs1_1, rs2_1, rd_1, rs1_2, rs2_2, rd_2;
  logic       regWrite1, regWrite2;
  logic [5:0] prs1_1, prs2_1, prd_1, oldprd_1, prs1_2, prs2_2, prd_2, oldprd_2;
  logic       commit_valid1, commit_valid2;
  logic [5:0] commit_preg1, commit_preg2;
  logic [6:0] free_count;
`ifdef RENAME_BUSY_TABLE_EN
  logic       wb_valid;
  logic [5:0] wb_preg;
  logic       rdy1_1, rdy2_1, rdy1_2, rdy2_2;
`endif

  dual_rename dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_1(rs1_1), .rs2_1(rs2_1), .rd_1(rd_1), .rs1_2(rs1_2), .rs2_2(rs2_2), .rd_2(rd_2),
    .regWrite1(regWrite1), .regWrite2(regWrite2), .out_valid(out_valid), .out_ready(out_ready),
    .prs1_1(prs1_1), .prs2_1(prs2_1), .prd_1(prd_1), .oldprd_1(oldprd_1),
    .prs1_2(prs1_2), .prs2_2(prs2_2), .prd_2(prd_2), .oldprd_2(oldprd_2),
    .commit_valid1(commit_valid1), .commit_preg1(commit_preg1),
    .commit_valid2(commit_valid2), .commit_preg2(commit_preg2),
`ifdef RENAME_BUSY_TABLE_EN
    .wb_valid(wb_valid), .wb_preg(wb_preg),
    .rdy1_1(rdy1_1), .rdy2_1(rdy2_1), .rdy1_2(rdy1_2), .rdy2_2(rdy2_2),
`endif
    .free_count(free_count)
  );

  typedef struct {
    int prs1_1; int prs2_1; int prd_1; int oldprd_1;
    int prs1_2; int prs2_2; int prd_2; int oldprd_2;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  int   fq[$];
  int   pend[$];
  int   rat[32];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int src(input int r);
    return (r == 0) ? 0 : rat[r];
  endfunction

  task automatic model_reset();
    sb.delete();
    fq.delete();
    pend.delete();
    for (int i = 0; i < 32; i++) rat[i] = i;
    for (int i = 32; i < 64; i++) fq.push_back(i);
  endtask

  task automatic idle();
    in_valid = 0; regWrite1 = 0; regWrite2 = 0; out_ready = 1;
    rs1_1 = 0; rs2_1 = 0; rd_1 = 0; rs1_2 = 0; rs2_2 = 0; rd_2 = 0;
    commit_valid1 = 0; commit_valid2 = 0; commit_preg1 = 0; commit_preg2 = 0;
`ifdef RENAME_BUSY_TABLE_EN
    wb_valid = 0; wb_preg = 0;
`endif
  endtask

  task automatic set_bundle(input int a, input int b, input int d, input bit w,
                            input int c, input int e, input int f, input bit x);
    in_valid = 1;
    rs1_1 = 5'(a); rs2_1 = 5'(b); rd_1 = 5'(d); regWrite1 = w;
    rs1_2 = 5'(c); rs2_2 = 5'(e); rd_2 = 5'(f); regWrite2 = x;
  endtask

  task automatic remove_pending(input int t);
    int idx;
    idx = -1;
    for (int i = 0; i < pend.size(); i++) if (idx < 0 && pend[i] == t) idx = i;
    if (idx >= 0) pend.delete(idx);
  endtask

  task automatic pick_commits();
    int idx;
    commit_valid1 = 0; commit_valid2 = 0;
    if (pend.size() > 0 && $urandom_range(0, 99) < 35) begin
      idx = $urandom_range(0, pend.size() - 1);
      commit_preg1 = 6'(pend[idx]); commit_valid1 = 1; pend.delete(idx);
    end
    if (pend.size() > 0 && $urandom_range(0, 99) < 35) begin
      idx = $urandom_range(0, pend.size() - 1);
      commit_preg2 = 6'(pend[idx]); commit_valid2 = 1; pend.delete(idx);
    end
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_free_count", free_count, 32);
    check("rst_prs1_1", prs1_1, 0); check("rst_prs2_1", prs2_1, 0);
    check("rst_prd_1", prd_1, 0);   check("rst_oldprd_1", oldprd_1, 0);
    check("rst_prs1_2", prs1_2, 0); check("rst_prs2_2", prs2_2, 0);
    check("rst_prd_2", prd_2, 0);   check("rst_oldprd_2", oldprd_2, 0);
    rst = 0;
  endtask

  // One cycle: reference model for the upcoming edge, then advance to the next negedge.
  task automatic step();
    exp_t e;
    bit er, acc, a1, a2;
    #2;
    er = ((sb.size() == 0) || (out_ready === 1'b1)) && (fq.size() >= 2);
    check("in_ready", in_ready, 32'(er));
    check("free_count", free_count, fq.size());
    acc = (in_valid === 1'b1) && er;
    e = '{default: 0};
    if (acc) begin
      a1 = regWrite1 && (rd_1 != 0);
      a2 = regWrite2 && (rd_2 != 0);
      e.prs1_1 = src(rs1_1);
      e.prs2_1 = src(rs2_1);
      if (a1) begin
        e.prd_1 = fq.pop_front(); e.oldprd_1 = rat[rd_1];
        rat[rd_1] = e.prd_1; pend.push_back(e.oldprd_1);
      end
      e.prs1_2 = src(rs1_2);
      e.prs2_2 = src(rs2_2);
      if (a2) begin
        e.prd_2 = fq.pop_front(); e.oldprd_2 = rat[rd_2];
        rat[rd_2] = e.prd_2; pend.push_back(e.oldprd_2);
      end
    end
    if (commit_valid1) fq.push_back(int'(commit_preg1));
    if (commit_valid2) fq.push_back(int'(commit_preg2));
    @(posedge clk);
    if (acc) sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compares whatever bundle the DUT presents against the scoreboard head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst === 1'b0) begin
        check("out_valid", out_valid, 32'(sb.size() != 0));
        if (out_valid === 1'b1 && sb.size() != 0) begin
          e = sb[0];
          check("prs1_1", prs1_1, e.prs1_1); check("prs2_1", prs2_1, e.prs2_1);
          check("prd_1", prd_1, e.prd_1);    check("oldprd_1", oldprd_1, e.oldprd_1);
          check("prs1_2", prs1_2, e.prs1_2); check("prs2_2", prs2_2, e.prs2_2);
          check("prd_2", prd_2, e.prd_2);    check("oldprd_2", oldprd_2, e.oldprd_2);
          if (out_ready === 1'b1) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin : stimulus
    do_reset();

    // addi x5 / add x6,x5,x1
    set_bundle(0, 0, 5, 1, 5, 1, 6, 1); step();
    check("t1_prd_1", prd_1, 32); check("t1_prd_2", prd_2, 33);
    check("t1_prs1_2", prs1_2, 32); check("t1_prs2_2", prs2_2, 1);
    check("t1_oldprd_1", oldprd_1, 5); check("t1_free_count", free_count, 30);
    idle(); step();

    // both slots write x7
    do_reset();
    set_bundle(0, 0, 7, 1, 0, 0, 7, 1); step();
    check("t2_prd_1", prd_1, 32); check("t2_prd_2", prd_2, 33);
    check("t2_oldprd_1", oldprd_1, 7); check("t2_oldprd_2", oldprd_2, 32);
    set_bundle(7, 0, 0, 0, 0, 0, 0, 0); step();
    check("t2_read_x7", prs1_1, 33);
    idle(); step();

    // rd=x0 with regWrite, and a store
    do_reset();
    set_bundle(3, 4, 0, 1, 2, 9, 9, 0); step();
    check("t3_prd_1", prd_1, 0); check("t3_prd_2", prd_2, 0);
    check("t3_oldprd_1", oldprd_1, 0); check("t3_free_count", free_count, 32);
    idle(); step();

    // exhaust the free list, then recycle p5/p6 through the wrapped pointers
    do_reset();
    for (int k = 0; k < 15; k++) begin
      set_bundle(0, 0, 2*k + 1, 1, 0, 0, 2*k + 2, 1); step();
    end
    check("t4_count2", free_count, 2); check("t4_ready_at2", in_ready, 1);
    set_bundle(0, 0, 31, 1, 0, 0, 1, 1); step();
    check("t4_count0", free_count, 0); check("t4_ready_at0", in_ready, 0);
    idle();
    remove_pending(5); remove_pending(6);
    commit_valid1 = 1; commit_preg1 = 6'd5; commit_valid2 = 1; commit_preg2 = 6'd6;
    step();
    idle();
    check("t4_count_after_free", free_count, 2); check("t4_ready_after_free", in_ready, 1);
    set_bundle(0, 0, 2, 1, 0, 0, 3, 1); step();
    check("t4_wrap_prd_1", prd_1, 5); check("t4_wrap_prd_2", prd_2, 6);
    idle(); step();

    // hold for three cycles with a commit during the hold, then reset mid-hold
    do_reset();
    set_bundle(0, 0, 8, 1, 0, 0, 9, 1); step();
    for (int h = 0; h < 3; h++) begin
      set_bundle(1, 2, 10, 1, 3, 4, 11, 1);
      out_ready = 0;
      commit_valid1 = 0;
      if (h == 1) begin
        remove_pending(8); commit_valid1 = 1; commit_preg1 = 6'd8;
      end
      step();
      check("t5_hold_valid", out_valid, 1);
      check("t5_hold_prd_1", prd_1, 32); check("t5_hold_prd_2", prd_2, 33);
    end
    check("t5_commit_in_hold", free_count, 31);
    do_reset();

`ifdef RENAME_BUSY_TABLE_EN
    set_bundle(0, 0, 5, 1, 0, 0, 0, 0); step();
    set_bundle(5, 0, 0, 0, 0, 0, 0, 0); step();
    check("t6_busy_not_ready", rdy1_1, 0);
    set_bundle(5, 0, 0, 0, 0, 0, 0, 0); wb_valid = 1; wb_preg = 6'd32; step();
    wb_valid = 0;
    check("t6_wb_bypass_ready", rdy1_1, 1);
    set_bundle(0, 0, 10, 1, 10, 0, 0, 0); step();
    check("t6_fwd_not_ready", rdy1_2, 0);
    idle(); step();
    do_reset();
`endif

    // randomized traffic with legal commits of stale tags
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 99) < 75);
      out_ready = ($urandom_range(0, 99) < 75);
      rs1_1 = 5'($urandom_range(0, 31)); rs2_1 = 5'($urandom_range(0, 31));
      rd_1  = 5'($urandom_range(0, 31)); regWrite1 = ($urandom_range(0, 99) < 80);
      rs1_2 = 5'($urandom_range(0, 31)); rs2_2 = 5'($urandom_range(0, 31));
      rd_2  = 5'($urandom_range(0, 31)); regWrite2 = ($urandom_range(0, 99) < 80);
      if ($urandom_range(0, 7) == 0) rd_2 = rd_1;
      if ($urandom_range(0, 7) == 0) rs1_2 = rd_1;
      pick_commits();
      step();
    end
    idle();
    for (int n = 0; n < 3; n++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
